// File: rtl/wb_regfile_scoreboard_if.sv
// Decode/issue and write-back bundle for the register-file scoreboard.
// The master side is the pipeline; the slave side is the register file.
interface wb_regfile_scoreboard_if #(
    parameter int unsigned XLEN = 32
);
    logic            wb_regwrite;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;

    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            rd_en;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;

    logic            iss_valid;
    logic            iss_regwrite;
    logic [4:0]      iss_rd;

    logic            stall;
    logic            sb_overflow;
    logic            sb_underflow;

    modport master (
        output wb_regwrite, wb_rd, wb_data,
        output rs1, rs2, rd_en,
        output iss_valid, iss_regwrite, iss_rd,
        input  rdata1, rdata2, stall, sb_overflow, sb_underflow
    );

    modport slave (
        input  wb_regwrite, wb_rd, wb_data,
        input  rs1, rs2, rd_en,
        input  iss_valid, iss_regwrite, iss_rd,
        output rdata1, rdata2, stall, sb_overflow, sb_underflow
    );
endinterface

// File: rtl/wb_regfile_scoreboard.sv
// Integer register file x0..x31 with registered, write-bypassed read ports
// and a per-register pending-write scoreboard that drives decode stall.
module wb_regfile_scoreboard #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 2
) (
    input logic                    clk,
    input logic                    rst,
    wb_regfile_scoreboard_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [XLEN-1:0]  regs     [32];
    logic [CNT_W-1:0] cnt      [32];
    logic [CNT_W-1:0] cnt_next [32];

    logic            wb_write;
    logic            ovf_hit;
    logic            unf_hit;
    logic [XLEN-1:0] rd_val1;
    logic [XLEN-1:0] rd_val2;
    logic            busy1;
    logic            busy2;

    assign wb_write = bus.wb_regwrite && (bus.wb_rd != 5'd0);

    // Read data seen by the capture flop; a same-cycle write-back wins.
    always_comb begin
        rd_val1 = '0;
        if (bus.rs1 != 5'd0) begin
            if (bus.wb_regwrite && (bus.wb_rd == bus.rs1)) begin
                rd_val1 = bus.wb_data;
            end else begin
                rd_val1 = regs[bus.rs1];
            end
        end
    end

    always_comb begin
        rd_val2 = '0;
        if (bus.rs2 != 5'd0) begin
            if (bus.wb_regwrite && (bus.wb_rd == bus.rs2)) begin
                rd_val2 = bus.wb_data;
            end else begin
                rd_val2 = regs[bus.rs2];
            end
        end
    end

    // Issue increments, retire decrements; both together cancel with no error.
    always_comb begin
        logic       inc;
        logic       dec;
        logic [4:0] ri;
        inc      = 1'b0;
        dec      = 1'b0;
        ri       = '0;
        ovf_hit  = 1'b0;
        unf_hit  = 1'b0;
        cnt_next = cnt;
        for (int unsigned r = 1; r < 32; r++) begin
            ri  = 5'(r);
            inc = bus.iss_valid && bus.iss_regwrite && (bus.iss_rd == ri);
            dec = bus.wb_regwrite && (bus.wb_rd == ri);
            case ({inc, dec})
                2'b10: begin
                    if (cnt[ri] == CNT_MAX) begin
                        ovf_hit = 1'b1;
                    end else begin
                        cnt_next[ri] = cnt[ri] + CNT_ONE;
                    end
                end
                2'b01: begin
                    if (cnt[ri] == '0) begin
                        unf_hit = 1'b1;
                    end else begin
                        cnt_next[ri] = cnt[ri] - CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
        cnt_next[0] = '0;
    end

    // A source whose last outstanding write retires now is covered by the bypass.
    always_comb begin
        busy1 = (bus.rs1 != 5'd0) && (cnt[bus.rs1] != '0) &&
                !((cnt[bus.rs1] == CNT_ONE) && bus.wb_regwrite && (bus.wb_rd == bus.rs1));
        busy2 = (bus.rs2 != 5'd0) && (cnt[bus.rs2] != '0) &&
                !((cnt[bus.rs2] == CNT_ONE) && bus.wb_regwrite && (bus.wb_rd == bus.rs2));
    end

    assign bus.stall = busy1 | busy2;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs[i] <= '0;
                cnt[i]  <= '0;
            end
            bus.rdata1       <= '0;
            bus.rdata2       <= '0;
            bus.sb_overflow  <= 1'b0;
            bus.sb_underflow <= 1'b0;
        end else begin
            if (wb_write) begin
                regs[bus.wb_rd] <= bus.wb_data;
            end
            for (int unsigned i = 0; i < 32; i++) begin
                cnt[i] <= cnt_next[i];
            end
            if (bus.rd_en) begin
                bus.rdata1 <= rd_val1;
                bus.rdata2 <= rd_val2;
            end
            if (ovf_hit) begin
                bus.sb_overflow <= 1'b1;
            end
            if (unf_hit) begin
                bus.sb_underflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
// Directed and randomized bench for wb_regfile_scoreboard against a
// pending-count reference model of the register file and scoreboard.
module tb_wb_regfile_scoreboard;
    localparam int unsigned XLEN     = 32;
    localparam int unsigned CNT_W    = 2;
    localparam int          MAX_PEND = (1 << CNT_W) - 1;

    logic clk;
    logic rst;

    wb_regfile_scoreboard_if #(.XLEN(XLEN)) bus ();

    wb_regfile_scoreboard #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [XLEN-1:0] m_reg  [32];
    int              m_pend [32];
    logic            m_ovf;
    logic            m_unf;
    logic [XLEN-1:0] m_rd1;
    logic [XLEN-1:0] m_rd2;
    logic            last_stall;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic m_busy(input logic [4:0] a, input logic wbw, input logic [4:0] wrd);
        if (a == 5'd0) return 1'b0;
        if (m_pend[a] == 0) return 1'b0;
        if (m_pend[a] == 1 && wbw && wrd == a) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [XLEN-1:0] m_read(input logic [4:0] a, input logic wbw,
                                               input logic [4:0] wrd, input logic [XLEN-1:0] wd);
        if (a == 5'd0) return '0;
        if (wbw && wrd == a) return wd;
        return m_reg[a];
    endfunction

    // One clock: drive, check stall before the edge, update model, check registered outputs.
    task automatic step(input logic r, input logic wbw, input logic [4:0] wrd, input logic [XLEN-1:0] wd,
                        input logic [4:0] a1, input logic [4:0] a2, input logic ren,
                        input logic iv, input logic irw, input logic [4:0] ird);
        logic same;
        rst              = r;
        bus.wb_regwrite  = wbw;
        bus.wb_rd        = wrd;
        bus.wb_data      = wd;
        bus.rs1          = a1;
        bus.rs2          = a2;
        bus.rd_en        = ren;
        bus.iss_valid    = iv;
        bus.iss_regwrite = irw;
        bus.iss_rd       = ird;
        #2;
        last_stall = bus.stall;
        check("stall", {31'd0, bus.stall}, {31'd0, m_busy(a1, wbw, wrd) | m_busy(a2, wbw, wrd)});
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[i]  = '0;
                m_pend[i] = 0;
            end
            m_rd1 = '0;
            m_rd2 = '0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (ren) begin
                m_rd1 = m_read(a1, wbw, wrd, wd);
                m_rd2 = m_read(a2, wbw, wrd, wd);
            end
            same = iv && irw && wbw && (ird == wrd);
            if (iv && irw && ird != 5'd0 && !same) begin
                if (m_pend[ird] == MAX_PEND) m_ovf = 1'b1;
                else m_pend[ird]++;
            end
            if (wbw && wrd != 5'd0 && !same) begin
                if (m_pend[wrd] == 0) m_unf = 1'b1;
                else m_pend[wrd]--;
            end
            if (wbw && wrd != 5'd0) m_reg[wrd] = wd;
        end
        #1;
        check("rdata1", bus.rdata1, m_rd1);
        check("rdata2", bus.rdata2, m_rd2);
        check("sb_overflow", {31'd0, bus.sb_overflow}, {31'd0, m_ovf});
        check("sb_underflow", {31'd0, bus.sb_underflow}, {31'd0, m_unf});
    endtask

    initial begin
        logic            rr, wbw, ren, iv, irw;
        logic [4:0]      wrd, a1, a2, ird;
        logic [XLEN-1:0] wd;

        rst = 1'b1;
        @(negedge clk);
        // step(rst, wbw, wrd, wdata, rs1, rs2, rd_en, iss_valid, iss_regwrite, iss_rd)
        step(1, 1, 5'd3, 32'hFFFF_FFFF, 5'd0, 5'd0, 1, 1, 1, 5'd3);
        step(1, 0, 5'd0, 32'h0, 5'd0, 5'd0, 0, 0, 0, 5'd0);

        step(0, 0, 5'd0, 32'h0, 5'd5, 5'd0, 1, 0, 0, 5'd0);
        check("reset_rdata1", bus.rdata1, 32'h0);
        check("reset_stall", {31'd0, last_stall}, 32'h0);

        step(0, 0, 5'd0, 32'h0, 5'd0, 5'd0, 0, 1, 1, 5'd7);
        step(0, 1, 5'd7, 32'hDEAD_BEEF, 5'd7, 5'd0, 1, 0, 0, 5'd0);
        check("bypass_x7", bus.rdata1, 32'hDEAD_BEEF);
        step(0, 0, 5'd0, 32'h0, 5'd7, 5'd0, 1, 0, 0, 5'd0);
        check("reread_x7", bus.rdata1, 32'hDEAD_BEEF);

        step(0, 1, 5'd0, 32'h1234_5678, 5'd0, 5'd0, 0, 1, 1, 5'd0);
        step(0, 0, 5'd0, 32'h0, 5'd0, 5'd0, 1, 0, 0, 5'd0);
        check("x0_reads_zero", bus.rdata2, 32'h0);
        check("x0_no_stall", {31'd0, last_stall}, 32'h0);

        step(0, 0, 5'd0, 32'h0, 5'd0, 5'd0, 0, 1, 1, 5'd3);
        step(0, 0, 5'd0, 32'h0, 5'd0, 5'd0, 0, 1, 1, 5'd3);
        step(0, 0, 5'd0, 32'h0, 5'd3, 5'd0, 0, 0, 0, 5'd0);
        check("x3_cnt2_stall", {31'd0, last_stall}, 32'h1);
        step(0, 1, 5'd3, 32'hAAAA_0001, 5'd3, 5'd0, 1, 0, 0, 5'd0);
        check("x3_first_retire_stall", {31'd0, last_stall}, 32'h1);
        step(0, 1, 5'd3, 32'hBBBB_0002, 5'd3, 5'd0, 1, 0, 0, 5'd0);
        check("x3_final_retire_stall", {31'd0, last_stall}, 32'h0);
        check("x3_final_retire_data", bus.rdata1, 32'hBBBB_0002);

        step(0, 1, 5'd4, 32'hC0DE_0004, 5'd4, 5'd0, 1, 1, 1, 5'd4);
        check("x4_same_cycle_stall", {31'd0, last_stall}, 32'h0);
        step(0, 0, 5'd0, 32'h0, 5'd4, 5'd4, 1, 0, 0, 5'd0);
        check("x4_visible", bus.rdata2, 32'hC0DE_0004);
        check("x4_no_underflow", {31'd0, bus.sb_underflow}, 32'h0);

        for (int i = 0; i < 4; i++) step(0, 0, 5'd0, 32'h0, 5'd0, 5'd0, 0, 1, 1, 5'd9);
        check("x9_overflow", {31'd0, bus.sb_overflow}, 32'h1);
        step(0, 1, 5'd10, 32'h0000_0010, 5'd9, 5'd0, 0, 0, 0, 5'd0);
        check("x9_held_stall", {31'd0, last_stall}, 32'h1);
        check("x10_underflow", {31'd0, bus.sb_underflow}, 32'h1);
        step(0, 0, 5'd0, 32'h0, 5'd0, 5'd0, 0, 0, 0, 5'd0);
        check("flags_sticky", {30'd0, bus.sb_overflow, bus.sb_underflow}, 32'h3);
        step(1, 0, 5'd0, 32'h0, 5'd0, 5'd0, 0, 0, 0, 5'd0);
        check("flags_cleared", {30'd0, bus.sb_overflow, bus.sb_underflow}, 32'h0);

        step(0, 0, 5'd0, 32'h0, 5'd0, 5'd0, 0, 1, 1, 5'd11);
        step(1, 0, 5'd0, 32'h0, 5'd0, 5'd0, 0, 0, 0, 5'd0);
        step(0, 1, 5'd11, 32'h0000_0011, 5'd11, 5'd0, 1, 0, 0, 5'd0);
        check("stale_retire_underflow", {31'd0, bus.sb_underflow}, 32'h1);
        step(1, 0, 5'd0, 32'h0, 5'd0, 5'd0, 0, 0, 0, 5'd0);

        for (int n = 0; n < 400; n++) begin
            rr  = ($urandom_range(63) == 0);
            wbw = ($urandom_range(1) == 1);
            wrd = 5'($urandom_range(7));
            wd  = $urandom;
            a1  = 5'($urandom_range(7));
            a2  = 5'($urandom_range(7));
            ren = ($urandom_range(3) != 0);
            iv  = ($urandom_range(1) == 1);
            irw = ($urandom_range(3) != 0);
            ird = 5'($urandom_range(7));
            step(rr, wbw, wrd, wd, a1, a2, ren, iv, irw, ird);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/wb_regfile_scoreboard.md
Name: wb_regfile_scoreboard

Overview:
- Register-file endpoint that consumes the write-back stage's (rd, RegWrite, data) stream. It holds the architectural integer registers x0..x31.
- Serves two registered read ports to decode, with write-to-read bypass.
- Keeps a per-register pending-write scoreboard: decode marks a destination at issue, and write-back retires it. A combinational stall is raised while a source operand still has an outstanding write.
- Sits between the decode/issue stage (read side) and the write-back stage (write side).

Parameters:
- XLEN, 32, data width of each register.
- CNT_W, 2, width of each per-register pending-write counter; maximum in-flight writes per register is 2^CNT_W-1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- wb_regwrite  input  1  write-back write enable (RegWrite from WB).
- wb_rd  input  5  write-back destination register.
- wb_data  input  XLEN  write-back data (DataOut_WB).
- rs1  input  5  read port 1 address.
- rs2  input  5  read port 2 address.
- rd_en  input  1  capture read data this cycle.
- rdata1  output  XLEN  registered read data, port 1.
- rdata2  output  XLEN  registered read data, port 2.
- iss_valid  input  1  decode issues an instruction this cycle.
- iss_regwrite  input  1  issued instruction writes a register.
- iss_rd  input  5  issued instruction's destination.
- stall  output  1  combinational: rs1 or rs2 has an unresolved pending write.
- sb_overflow  output  1  sticky error: issue to a register whose counter is saturated.
- sb_underflow  output  1  sticky error: retire to a register whose counter is zero.

Behaviour:
- Reset (synchronous, rst=1 at edge):
  - all 32 registers, all counters, rdata1, rdata2, sb_overflow and sb_underflow clear to 0.
  - wb and iss inputs are ignored on that edge.
- Register write: on an edge with wb_regwrite=1 and wb_rd!=0, reg[wb_rd] <= wb_data.
  - Writes to x0 are discarded.
  - x0 always reads 0.
- Reads, latency 1:
  - On an edge with rd_en=1, rdataN <= (rsN==0) ? 0 : (wb_regwrite && wb_rd==rsN) ? wb_data : reg[rsN].
  - The write bypass applies in the same cycle as the write.
  - With rd_en=0, rdataN holds.
- Scoreboard counter cnt[r], per register, r=1..31; cnt[0] is constant 0.
  - inc = iss_valid && iss_regwrite && iss_rd==r.
  - dec = wb_regwrite && wb_rd==r.
  - inc only: cnt+1. If cnt is already at max, it holds and sb_overflow <= 1.
  - dec only: cnt-1. If cnt is 0, it holds at 0 and sb_underflow <= 1. The register write is still performed.
  - inc and dec in the same cycle: cnt unchanged, no error flag, even at 0 or max.
  - Neither: hold.
- Stall, combinational from current state and inputs:
  - busyN = rsN!=0 && cnt[rsN]!=0 && !(cnt[rsN]==1 && wb_regwrite && wb_rd==rsN).
  - stall = busy1 | busy2.
  - The final outstanding write retiring this cycle does not stall, because the bypass delivers its data.
  - stall does not depend on iss_*. An instruction never stalls on its own destination.
- Error flags are sticky until reset. They do not block operation.
- Reset asserted mid-operation discards all pending state. A write-back arriving after reset for a pre-reset issue raises sb_underflow.

Test Plan:
- After reset, read x5 and x0 with rd_en=1 -> next cycle rdata1=0, rdata2=0; stall=0; both flags 0.
- WB writes x7=0xDEADBEEF while rs1=7, rd_en=1 in the same cycle -> next cycle rdata1=0xDEADBEEF (bypass). A later read without a write still returns 0xDEADBEEF.
- WB writes x0=0x12345678, then read rs2=0 -> rdata2=0. cnt[0] is never incremented and no stall occurs on rs=0.
- Issue to x3 twice (cnt=2), rs1=3 -> stall=1.
  - Retire x3 once -> stall stays 1 (cnt=1).
  - In the cycle of the second retire, stall=0 (final-retire bypass), and rdata1 captures the retire data.
- Issue to x4 and retire x4 in the same cycle at cnt=0 -> cnt stays 0, sb_underflow=0, stall=0 with rs1=4; the x4 write is visible.
- Issue to x9 four times with CNT_W=2 -> the 4th issue sets sb_overflow=1 and cnt holds at 3.
  - Retire x9 with cnt=0 on another register (x10) -> sb_underflow=1.
  - Both flags clear only on rst.
